// File: rtl/fp16_dot_seq.sv
// FP16 dot-product sequencer. Feeds one (x, y, acc) triple at a time to an external fused
// multiply-add unit, waits FMA_LAT cycles for it to settle, captures the result back into the
// accumulator and presents the finished sum with sticky flags and an element count.
//
// Ports:
//   clk, reset_n                 clock, asynchronous active-low reset
//   in_valid/in_ready            element handshake; in_x/in_y operands, in_last closes the vector,
//                                in_rm rounding mode (taken from the first element only)
//   fma_x/y/z, fma_rm            registered operands to the fma16 datapath
//   fma_mul/add/negp/negz        fixed fma16 control bits (x*y + z)
//   fma_result, fma_flags        fma16 result and {nv,of,uf,nx} flags
//   out_valid/out_ready          result handshake; out_sum, out_flags, out_count held while valid
module fp16_dot_seq #(
   parameter int unsigned FMA_LAT = 1,
   parameter int unsigned CNT_W   = 8
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [15:0]      in_x,
   input  logic [15:0]      in_y,
   input  logic             in_last,
   input  logic [1:0]       in_rm,
   output logic [15:0]      fma_x,
   output logic [15:0]      fma_y,
   output logic [15:0]      fma_z,
   output logic             fma_mul,
   output logic             fma_add,
   output logic             fma_negp,
   output logic             fma_negz,
   output logic [1:0]       fma_rm,
   input  logic [15:0]      fma_result,
   input  logic [3:0]       fma_flags,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [15:0]      out_sum,
   output logic [3:0]       out_flags,
   output logic [CNT_W-1:0] out_count
);

   typedef enum logic [1:0] {StAccept, StExec, StHold} state_e;

   localparam logic [3:0] WaitInit = 4'(FMA_LAT - 1);

   state_e           state_q, state_d;
   logic             first_q, first_d;
   logic             last_q, last_d;
   logic [3:0]       wait_q, wait_d;
   logic [15:0]      acc_q, acc_d;
   logic [15:0]      x_q, x_d;
   logic [15:0]      y_q, y_d;
   logic [15:0]      z_q, z_d;
   logic [1:0]       rm_q, rm_d;
   logic [3:0]       flags_q, flags_d;
   logic [CNT_W-1:0] count_q, count_d;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= StAccept;
         first_q <= 1'b1;
         last_q  <= 1'b0;
         wait_q  <= '0;
         acc_q   <= '0;
         x_q     <= '0;
         y_q     <= '0;
         z_q     <= '0;
         rm_q    <= '0;
         flags_q <= '0;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         first_q <= first_d;
         last_q  <= last_d;
         wait_q  <= wait_d;
         acc_q   <= acc_d;
         x_q     <= x_d;
         y_q     <= y_d;
         z_q     <= z_d;
         rm_q    <= rm_d;
         flags_q <= flags_d;
         count_q <= count_d;
      end
   end

   always_comb begin
      state_d = state_q;
      first_d = first_q;
      last_d  = last_q;
      wait_d  = wait_q;
      acc_d   = acc_q;
      x_d     = x_q;
      y_d     = y_q;
      z_d     = z_q;
      rm_d    = rm_q;
      flags_d = flags_q;
      count_d = count_q;
      unique case (state_q)
         StAccept: begin
            // in_ready is high in this state, so in_valid alone is a handshake
            if (in_valid) begin
               x_d     = in_x;
               y_d     = in_y;
               z_d     = first_q ? 16'h0000 : acc_q;
               last_d  = in_last;
               wait_d  = WaitInit;
               first_d = 1'b0;
               if (first_q) begin
                  rm_d    = in_rm;
                  flags_d = '0;
                  count_d = '0;
               end
               state_d = StExec;
            end
         end
         StExec: begin
            if (wait_q == 4'd0) begin
               acc_d   = fma_result;
               flags_d = flags_q | fma_flags;
               if (count_q != '1) count_d = count_q + CNT_W'(1);
               state_d = last_q ? StHold : StAccept;
            end else begin
               wait_d = wait_q - 4'd1;
            end
         end
         StHold: begin
            if (out_ready) begin
               first_d = 1'b1;
               state_d = StAccept;
            end
         end
         default: state_d = StAccept;
      endcase
   end

   assign in_ready  = (state_q == StAccept);
   assign out_valid = (state_q == StHold);
   assign fma_x     = x_q;
   assign fma_y     = y_q;
   assign fma_z     = z_q;
   assign fma_rm    = rm_q;
   assign fma_mul   = 1'b1;
   assign fma_add   = 1'b1;
   assign fma_negp  = 1'b0;
   assign fma_negz  = 1'b0;
   assign out_sum   = acc_q;
   assign out_flags = flags_q;
   assign out_count = count_q;

endmodule

// File: tb/tb_fp16_dot_seq.sv
// Bench for fp16_dot_seq: two lanes (FMA_LAT=1/CNT_W=8 and FMA_LAT=3/CNT_W=3), each with an
// fma16 stand-in that only returns the true result once operands have settled FMA_LAT cycles.
module tb_fp16_dot_seq;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   typedef struct packed {
      logic [15:0] sum;
      logic [3:0]  flags;
      logic [31:0] count;
   } exp_t;

   task automatic chk(input int lane, input string name, input logic [31:0] got,
                      input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL lane%0d %s: got %h expected %h", lane, name, got, exp);
      end
   endtask

   function automatic bit is_nan(input logic [15:0] v);
      return (v[14:10] == 5'h1f) && (v[9:0] != 10'd0);
   endfunction

   function automatic bit is_inf(input logic [15:0] v);
      return (v[14:10] == 5'h1f) && (v[9:0] == 10'd0);
   endfunction

   function automatic bit is_zero(input logic [15:0] v);
      return v[14:0] == 15'd0;
   endfunction

   // Only integer-valued FP16 numbers are ever generated
   function automatic int to_int(input logic [15:0] v);
      int e, m, mag;
      if (is_zero(v)) return 0;
      e   = int'(v[14:10]) - 15;
      m   = int'({1'b1, v[9:0]});
      mag = (e >= 10) ? (m <<< (e - 10)) : (m >>> (10 - e));
      return v[15] ? -mag : mag;
   endfunction

   function automatic logic [15:0] from_int(input int v);
      logic [31:0] a, sh;
      int p;
      if (v == 0) return 16'h0000;
      a = (v < 0) ? 32'(-v) : 32'(v);
      p = 0;
      for (int i = 0; i < 12; i++) if (a[i]) p = i;
      sh = a << (10 - p);
      return {v < 0, 5'(p + 15), sh[9:0]};
   endfunction

   // Reference fma: {flags, result}. Flag rule for finite results is arbitrary (stand-in only):
   // nx when |r| > 64, of when |r| > 256.
   function automatic logic [19:0] fma_ref(input logic [15:0] x, y, z);
      logic ps;
      int   r;
      ps = x[15] ^ y[15];
      if (is_nan(x) || is_nan(y) || is_nan(z)) return {4'b0000, 16'h7E00};
      if ((is_inf(x) && is_zero(y)) || (is_zero(x) && is_inf(y))) return {4'b1000, 16'h7E00};
      if (is_inf(x) || is_inf(y)) begin
         if (is_inf(z) && (z[15] != ps)) return {4'b1000, 16'h7E00};
         return {4'b0000, ps, 15'h7C00};
      end
      if (is_inf(z)) return {4'b0000, z};
      r = to_int(x) * to_int(y) + to_int(z);
      return {1'b0, (r > 256) || (r < -256), 1'b0, (r > 64) || (r < -64), from_int(r)};
   endfunction

   function automatic logic [15:0] rnd_op();
      int n;
      n = int'($urandom_range(0, 63));
      if (n == 0) return 16'h7C00;
      if (n == 1) return 16'hFC00;
      return from_int(int'($urandom_range(0, 16)) - 8);
   endfunction

   for (genvar g = 0; g < 2; g++) begin : g_lane
      localparam int unsigned Lat = (g == 0) ? 1 : 3;
      localparam int unsigned Cw  = (g == 0) ? 8 : 3;

      logic          reset_n;
      logic          in_valid, in_ready, in_last;
      logic [15:0]   in_x, in_y;
      logic [1:0]    in_rm;
      logic [15:0]   fma_x, fma_y, fma_z, fma_result;
      logic          fma_mul, fma_add, fma_negp, fma_negz;
      logic [1:0]    fma_rm;
      logic [3:0]    fma_flags;
      logic          out_valid, out_ready;
      logic [15:0]   out_sum;
      logic [3:0]    out_flags;
      logic [Cw-1:0] out_count;
      logic [19:0]   ref_now;
      int unsigned   age = 255;
      bit            done = 1'b0;
      exp_t          exp_q[$];
      logic [15:0]   vx [16];
      logic [15:0]   vy [16];
      logic [1:0]    vr [16];

      fp16_dot_seq #(.FMA_LAT(Lat), .CNT_W(Cw)) u_dut (
         .clk        (clk),
         .reset_n    (reset_n),
         .in_valid   (in_valid),
         .in_ready   (in_ready),
         .in_x       (in_x),
         .in_y       (in_y),
         .in_last    (in_last),
         .in_rm      (in_rm),
         .fma_x      (fma_x),
         .fma_y      (fma_y),
         .fma_z      (fma_z),
         .fma_mul    (fma_mul),
         .fma_add    (fma_add),
         .fma_negp   (fma_negp),
         .fma_negz   (fma_negz),
         .fma_rm     (fma_rm),
         .fma_result (fma_result),
         .fma_flags  (fma_flags),
         .out_valid  (out_valid),
         .out_ready  (out_ready),
         .out_sum    (out_sum),
         .out_flags  (out_flags),
         .out_count  (out_count)
      );

      // fma16 stand-in: result is garbage until Lat edges after the operands were loaded
      always @(posedge clk) begin
         if (in_valid && in_ready) age <= 0;
         else if (age < 255) age <= age + 1;
      end
      assign ref_now    = fma_ref(fma_x, fma_y, fma_z);
      assign fma_result = (age >= Lat - 1) ? ref_now[15:0] : (ref_now[15:0] ^ 16'h5A5A);
      assign fma_flags  = (age >= Lat - 1) ? ref_now[19:16] : 4'b0101;

      // Compare process: every cycle a result is presented, check it against the model
      always @(negedge clk) begin
         #1;
         if (reset_n && out_valid) begin
            if (exp_q.size() == 0) begin
               chk(g, "unexpected out_valid", 32'(out_valid), 32'd0);
            end else begin
               chk(g, "out_sum", 32'(out_sum), 32'(exp_q[0].sum));
               chk(g, "out_flags", 32'(out_flags), 32'(exp_q[0].flags));
               chk(g, "out_count", 32'(out_count), exp_q[0].count);
               if (out_ready) void'(exp_q.pop_front());
            end
            chk(g, "in_ready while out_valid", 32'(in_ready), 32'd0);
         end
      end

      task automatic check_zero(input string tag);
         chk(g, {tag, " fma_x"}, 32'(fma_x), 32'd0);
         chk(g, {tag, " fma_y"}, 32'(fma_y), 32'd0);
         chk(g, {tag, " fma_z"}, 32'(fma_z), 32'd0);
         chk(g, {tag, " fma_rm"}, 32'(fma_rm), 32'd0);
         chk(g, {tag, " out_sum"}, 32'(out_sum), 32'd0);
         chk(g, {tag, " out_flags"}, 32'(out_flags), 32'd0);
         chk(g, {tag, " out_count"}, 32'(out_count), 32'd0);
         chk(g, {tag, " out_valid"}, 32'(out_valid), 32'd0);
         chk(g, {tag, " fma ctrl"}, 32'({fma_mul, fma_add, fma_negp, fma_negz}), 32'b1100);
      endtask

      // Called just after a negedge; returns just after the negedge following capture
      task automatic send_elem(input logic [15:0] x, y, input bit last, input logic [1:0] rm,
                               input logic [15:0] exp_z, input logic [1:0] exp_rm);
         int guard = 0;
         in_valid = 1'b1;
         in_x     = x;
         in_y     = y;
         in_last  = last;
         in_rm    = rm;
         while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
         end
         if (!in_ready) begin
            chk(g, "in_ready timeout", 32'(in_ready), 32'd1);
            in_valid = 1'b0;
            return;
         end
         @(posedge clk);
         for (int i = 0; i <= int'(Lat); i++) begin
            @(negedge clk);
            if (i < int'(Lat)) begin
               chk(g, "fma_x", 32'(fma_x), 32'(x));
               chk(g, "fma_y", 32'(fma_y), 32'(y));
               chk(g, "fma_z", 32'(fma_z), 32'(exp_z));
               chk(g, "fma_rm", 32'(fma_rm), 32'(exp_rm));
               chk(g, "in_ready in exec", 32'(in_ready), 32'd0);
               chk(g, "out_valid in exec", 32'(out_valid), 32'd0);
               // junk offered while busy must be ignored
               in_valid = 1'($urandom_range(0, 1));
               in_x     = rnd_op();
               in_y     = rnd_op();
               in_last  = 1'($urandom_range(0, 1));
               in_rm    = 2'($urandom_range(0, 3));
            end else begin
               in_valid = 1'b0;
               chk(g, "in_ready after capture", 32'(in_ready), 32'(!last));
               chk(g, "out_valid after capture", 32'(out_valid), 32'(last));
            end
         end
      endtask

      task automatic run_vec(input int n);
         logic [15:0] acc;
         logic [3:0]  fl;
         logic [19:0] r;
         logic [15:0] zs [16];
         exp_t        e;
         int          maxc;
         acc = 16'h0000;
         fl  = 4'd0;
         for (int k = 0; k < n; k++) begin
            zs[k] = acc;
            r     = fma_ref(vx[k], vy[k], acc);
            acc   = r[15:0];
            fl    = fl | r[19:16];
         end
         maxc    = (1 << Cw) - 1;
         e.sum   = acc;
         e.flags = fl;
         e.count = 32'((n > maxc) ? maxc : n);
         exp_q.push_back(e);
         for (int k = 0; k < n; k++) send_elem(vx[k], vy[k], k == n - 1, vr[k], zs[k], vr[0]);
      endtask

      task automatic drain(input int hold);
         if (!out_valid) begin
            chk(g, "out_valid before drain", 32'(out_valid), 32'd1);
            return;
         end
         for (int i = 0; i < hold; i++) begin
            out_ready = 1'b0;
            @(negedge clk);
            chk(g, "out_valid held", 32'(out_valid), 32'd1);
            chk(g, "in_ready in hold", 32'(in_ready), 32'd0);
         end
         out_ready = 1'b1;
         @(negedge clk);
         out_ready = 1'b0;
         chk(g, "out_valid after handshake", 32'(out_valid), 32'd0);
         chk(g, "in_ready after handshake", 32'(in_ready), 32'd1);
      endtask

      initial begin
         reset_n   = 1'b0;
         in_valid  = 1'b0;
         in_x      = '0;
         in_y      = '0;
         in_last   = 1'b0;
         in_rm     = '0;
         out_ready = 1'b0;
         repeat (3) @(negedge clk);
         check_zero("reset");
         reset_n = 1'b1;
         chk(g, "in_ready after reset", 32'(in_ready), 32'd1);

         // single element 1.0 * 2.0
         vx[0] = 16'h3C00; vy[0] = 16'h4000; vr[0] = 2'b10;
         run_vec(1);
         chk(g, "single sum", 32'(out_sum), 32'h4000);
         chk(g, "single flags", 32'(out_flags), 32'h0);
         chk(g, "single count", 32'(out_count), 32'd1);
         chk(g, "single rm", 32'(fma_rm), 32'd2);
         drain(0);

         // (1*2) + (2*3) = 8, then consumer stalls three cycles
         vx[0] = 16'h3C00; vy[0] = 16'h4000; vr[0] = 2'b01;
         vx[1] = 16'h4000; vy[1] = 16'h4200; vr[1] = 2'b11;
         run_vec(2);
         chk(g, "pair z2", 32'(fma_z), 32'h4000);
         chk(g, "pair sum", 32'(out_sum), 32'h4800);
         chk(g, "pair count", 32'(out_count), 32'd2);
         chk(g, "pair rm from first", 32'(fma_rm), 32'd1);
         drain(3);

         // 0 * inf raises nv, which stays sticky; next vector starts clean
         vx[0] = 16'h0000; vy[0] = 16'h7C00; vr[0] = 2'b00;
         vx[1] = 16'h3C00; vy[1] = 16'h3C00; vr[1] = 2'b00;
         run_vec(2);
         chk(g, "nv sticky", 32'(out_flags), 32'h8);
         chk(g, "nan accumulated", 32'(out_sum), 32'h7E00);
         drain(1);
         vx[0] = 16'h3C00; vy[0] = 16'h3C00;
         run_vec(1);
         chk(g, "flags cleared", 32'(out_flags), 32'h0);
         chk(g, "fresh sum", 32'(out_sum), 32'h3C00);
         drain(0);

         // nine 1*1 elements: count saturates for the narrow counter
         for (int k = 0; k < 9; k++) begin
            vx[k] = 16'h3C00; vy[k] = 16'h3C00; vr[k] = 2'b00;
         end
         run_vec(9);
         chk(g, "nine sum", 32'(out_sum), 32'h4880);
         chk(g, "nine count", 32'(out_count), (Cw == 3) ? 32'd7 : 32'd9);
         drain(2);

         // reset during EXEC of the second element
         send_elem(16'h4000, 16'h4000, 1'b0, 2'b11, 16'h0000, 2'b11);
         in_valid = 1'b1; in_x = 16'h4000; in_y = 16'h4200; in_last = 1'b1; in_rm = 2'b01;
         @(posedge clk);
         #1;
         reset_n = 1'b0;
         #1;
         check_zero("mid reset");
         in_valid = 1'b0;
         @(negedge clk);
         reset_n = 1'b1;
         chk(g, "in_ready after mid reset", 32'(in_ready), 32'd1);
         vx[0] = 16'h3C00; vy[0] = 16'h4200; vr[0] = 2'b00;
         run_vec(1);
         chk(g, "post reset sum", 32'(out_sum), 32'h4200);
         chk(g, "post reset count", 32'(out_count), 32'd1);
         drain(0);

         // random vectors
         for (int v = 0; v < 30; v++) begin
            int n;
            n = int'($urandom_range(1, 12));
            for (int k = 0; k < n; k++) begin
               vx[k] = rnd_op();
               vy[k] = rnd_op();
               vr[k] = 2'($urandom_range(0, 3));
            end
            run_vec(n);
            drain(int'($urandom_range(0, 3)));
         end
         chk(g, "model queue drained", 32'(exp_q.size()), 32'd0);
         done = 1'b1;
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: lanes not done (lane0=%0d lane1=%0d, required 1)",
               g_lane[0].done, g_lane[1].done);
      $fatal(1);
   end

   initial begin
      wait (g_lane[0].done && g_lane[1].done);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/fp16_dot_seq.md
FP16_DOT_SEQ -- requirements
Module: fp16_dot_seq

Interface
REQ-001 SHALL have parameter FMA_LAT, default 1, meaning cycles allowed for the external fma16 datapath to settle (legal 1..15).
REQ-002 SHALL have parameter CNT_W, default 8, meaning width of the element counter.
REQ-003 SHALL have one clock; reset is asynchronous and active-low.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 reset_n  input  1  asynchronous active-low reset.
REQ-006 in_valid  input  1  element offered.
REQ-007 in_ready  output  1  sequencer can accept an element.
REQ-008 in_x, in_y  input  16 each  FP16 operand pair.
REQ-009 in_last  input  1  element closes the current vector.
REQ-010 in_rm  input  2  rounding mode, sampled with the first element of a vector only.
REQ-011 fma_x, fma_y, fma_z  output  16 each  registered operands to fma16.
REQ-012 fma_mul, fma_add, fma_negp, fma_negz  output  1 each  fma16 control bits.
REQ-013 fma_rm  output  2  registered rounding mode to fma16.
REQ-014 fma_result  input  16  fma16 result.
REQ-015 fma_flags  input  4  fma16 flags {nv,of,uf,nx}.
REQ-016 out_valid  output  1  dot product available.
REQ-017 out_ready  input  1  consumer accepts the result.
REQ-018 out_sum  output  16  FP16 dot product.
REQ-019 out_flags  output  4  sticky OR of fma_flags over the vector.
REQ-020 out_count  output  CNT_W  elements in the vector, saturating at all-ones.

Function
REQ-021 SHALL compute acc = x*y + acc per element through the external fma16, with acc = +0 (16'h0000) for the first element of each vector.
REQ-022 fma_mul and fma_add SHALL be constant 1; fma_negp and fma_negz SHALL be constant 0.
REQ-023 States SHALL be ACCEPT, EXEC, HOLD; in_ready=1 only in ACCEPT; out_valid=1 only in HOLD.
REQ-024 ACCEPT: on in_valid&in_ready, register in_x/in_y to fma_x/fma_y, acc (or 0 if first) to fma_z, in_rm to fma_rm if first, load wait counter with FMA_LAT-1, go EXEC; otherwise remain ACCEPT.
REQ-025 EXEC: decrement counter each edge; on the edge where counter is 0, capture fma_result into acc, OR fma_flags into sticky flags, increment count (saturating), go HOLD if the element was last, else ACCEPT.
REQ-026 fma_x/y/z/rm SHALL stay stable throughout EXEC and until the next accepted element.
REQ-027 Latency: element accepted at edge E0 is captured at edge E0+FMA_LAT; a last element gives out_valid from E0+FMA_LAT; throughput one element per FMA_LAT+1 cycles.
REQ-028 HOLD: out_sum=acc, out_flags, out_count held stable until out_valid&out_ready; then go ACCEPT and mark next element as first.
REQ-029 in_ready SHALL not depend combinationally on out_ready; a handshake in HOLD gives in_ready=1 on the following cycle.
REQ-030 Sticky flags and count SHALL clear when the first element of a new vector is accepted.
REQ-031 NaN/Inf results SHALL be accumulated unmodified; no special-casing in the sequencer.
REQ-032 in_valid with in_ready low SHALL be ignored (no state change).

Reset
REQ-033 reset_n low SHALL immediately force ACCEPT, first=1, acc=0, fma_x/y/z=0, fma_rm=0, counter=0, out_sum=0, out_flags=0, out_count=0, out_valid=0.
REQ-034 Reset mid-vector or in EXEC/HOLD SHALL discard partial results; in_ready=1 on the first cycle after release.

Verification
REQ-035 Single element 3C00*4000, last=1, FMA_LAT=1 -> out_valid one edge after accept, out_sum=4000, out_flags=0, out_count=1.
REQ-036 Vector (3C00,4000),(4000,4200) last -> second fma_z=4000, out_sum=4800, out_count=2.
REQ-037 out_ready low 3 cycles in HOLD -> out_valid, out_sum stable, in_ready=0; in_ready=1 cycle after handshake.
REQ-038 Element 0000*7C00 (fma_flags nv) then 3C00*3C00 last -> out_flags[3]=1; next vector 3C00*3C00 -> out_flags=0.
REQ-039 FMA_LAT=3, single element -> fma operands stable 3 cycles, out_valid at E0+3.
REQ-040 reset_n pulsed low during EXEC of second element -> all outputs 0, next vector starts from acc=0.
